// File: rtl/collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : collector                                                    |
// | Description : 8N1 UART receiver feeding a small byte FIFO presented as an  |
// |               AXI4-Stream-style byte stream, with framing-error and        |
// |               overrun status outputs.                                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module collector #(
  parameter int unsigned CLK_FREQ   = 16000000,
  parameter int unsigned BAUD       = 57600,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  EOL        = 8'h0A
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned DIVISOR = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W   = $clog2(DIVISOR);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);

  // First sample lands mid start bit, later samples one full bit apart.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIVISOR - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  logic             rx_meta;
  logic             rx_s;
  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shreg, shreg_d;
  logic             frame_err_d;
  logic             baud_tick;
  logic             push;

  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic             empty, full, pop, wr_en;
  logic [8:0]       head;

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  assign baud_tick = (cnt == '0);

  // Receiver state register with baud counter, bit index and shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'h00;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bit_idx     <= bit_idx_d;
      shreg       <= shreg_d;
      o_frame_err <= frame_err_d;
    end
  end

  // Next-state logic: sample at each counter expiry, push on a good stop bit.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    bit_idx_d   = bit_idx;
    shreg_d     = shreg;
    push        = 1'b0;
    frame_err_d = 1'b0;
    if (state != IDLE && !baud_tick) begin
      cnt_d = cnt - CNT_W'(1);
    end
    case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            cnt_d     = FULL_LOAD;
            bit_idx_d = 3'd0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          shreg_d   = {rx_s, shreg[7:1]};
          cnt_d     = FULL_LOAD;
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO flags: pointers carry one extra wrap bit to tell full from empty.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign o_tvalid = !empty;
  assign pop      = o_tvalid && i_tready;
  assign wr_en    = push && (!full || pop);
  assign head     = mem[rd_ptr[PTR_W-1:0]];

  // Storage is never reset, so the head is masked while the FIFO is empty.
  assign o_tdata  = o_tvalid ? head[7:0] : 8'h00;
  assign o_tlast  = o_tvalid && head[8];

  // FIFO storage write; tlast is precomputed alongside the byte.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr[PTR_W-1:0]] <= {(shreg == EOL), shreg};
    end
  end

  // FIFO pointers and sticky overrun flag for bytes dropped while full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
      end
      if (push && full && !pop) begin
        o_overrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_collector                                                 |
// | Description : Self-checking bench for collector: UART frames in, stream    |
// |               beats compared against a queue-based reference model.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_collector;

  localparam int         DEPTH = 4;
  localparam logic [7:0] EOL   = 8'h0A;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       uart_rx = 1'b1;
  logic       tready  = 1'b1;
  logic [7:0] tdata;
  logic       tlast, tvalid, frame_err, overrun;

  collector #(
    .CLK_FREQ  (1000000),
    .BAUD      (100000),
    .FIFO_DEPTH(DEPTH),
    .EOL       (EOL)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_uart_rx  (uart_rx),
    .o_tdata    (tdata),
    .o_tlast    (tlast),
    .o_tvalid   (tvalid),
    .i_tready   (tready),
    .o_frame_err(frame_err),
    .o_overrun  (overrun)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         errors   = 0;
  int         cyc      = 0;
  int         fe_count = 0;
  logic [8:0] beats[$];
  int         beat_cyc[$];
  logic [8:0] exp_q[$];
  logic [8:0] model_fifo[$];
  logic       model_ovr = 1'b0;
  logic       hold_prev = 1'b0;
  logic [8:0] hold_val  = 9'h000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [8:0] ent(input logic [7:0] b);
    return {(b == EOL), b};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record accepted beats, count frame errors, check stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) begin
        chk("hold_valid", {31'd0, tvalid}, 32'd1);
        chk("hold_data", {23'd0, tlast, tdata}, {23'd0, hold_val});
      end
      if (tvalid && tready) begin
        beats.push_back({tlast, tdata});
        beat_cyc.push_back(cyc);
      end
      if (frame_err) fe_count++;
      hold_prev = tvalid && !tready;
      hold_val  = {tlast, tdata};
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame; optionally pulse tready in one bit-time slot.
  task automatic send(input logic [7:0] b, input logic stop_bit, input int pulse_at, input int nticks);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < nticks; i++) begin
      uart_rx = fr[i / 10];
      if (pulse_at >= 0) tready = (i == pulse_at);
      tick();
    end
    uart_rx = 1'b1;
  endtask

  // Reference model: a frame either streams straight out or lands in a bounded queue.
  task automatic model_frame(input logic [7:0] b, input logic blocked);
    if (!blocked) exp_q.push_back(ent(b));
    else if (model_fifo.size() < DEPTH) model_fifo.push_back(ent(b));
    else model_ovr = 1'b1;
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_count"}, beats.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++)
      chk(tag, {23'd0, beats[i]}, {23'd0, exp_q[i]});
    beats.delete();
    beat_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    uart_rx = 1'b1;
    tready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    beats.delete();
    beat_cyc.delete();
    exp_q.delete();
    model_fifo.delete();
    model_ovr = 1'b0;
    fe_count = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] rb[5];
    int         k;
    int         span;

    // Reset state
    repeat (3) tick();
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tdata", {24'd0, tdata}, 32'd0);
    chk("rst_tlast", {31'd0, tlast}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Single bytes, plain and end-of-line
    send(8'h55, 1'b1, -1, 100); model_frame(8'h55, 1'b0);
    repeat (5) tick();
    check_beats("byte55");
    send(8'h0A, 1'b1, -1, 100); model_frame(8'h0A, 1'b0);
    repeat (5) tick();
    check_beats("byte0A");

    // Short low glitch on an idle line
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (20) tick();
    check_beats("glitch");
    chk("glitch_fe", fe_count, 0);

    // Framing error followed by a held-low line, then recovery
    send(8'hA5, 1'b0, -1, 100);
    uart_rx = 1'b0;
    repeat (40) tick();
    uart_rx = 1'b1;
    repeat (5) tick();
    chk("fe_pulses", fe_count, 1);
    check_beats("fe_nobeat");
    send(8'h3C, 1'b1, -1, 100); model_frame(8'h3C, 1'b0);
    repeat (5) tick();
    check_beats("after_fe");

    // Random stream with random gaps, consumer always ready
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) b = EOL;
      send(b, 1'b1, -1, 100);
      model_frame(b, 1'b0);
      repeat ($urandom_range(0, 15)) tick();
    end
    repeat (5) tick();
    check_beats("rand_stream");

    // Back-pressure: four bytes queue up, then drain back to back
    tready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), 1'b1, -1, 100);
      model_frame(8'(i), 1'b1);
    end
    repeat (3) tick();
    chk("bp_tvalid", {31'd0, tvalid}, 32'd1);
    chk("bp_tdata", {24'd0, tdata}, 32'h01);
    chk("bp_overrun", {31'd0, overrun}, {31'd0, model_ovr});
    tready = 1'b1;
    repeat (8) tick();
    span = (beat_cyc.size() == 4) ? beat_cyc[3] - beat_cyc[0] : -1;
    chk("bp_consecutive", span, 3);
    exp_q = model_fifo;
    model_fifo.delete();
    check_beats("bp_drain");

    // Overrun: fifth byte dropped, flag is sticky
    tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'h10 + 8'(i), 1'b1, -1, 100);
      model_frame(8'h10 + 8'(i), 1'b1);
    end
    chk("ovr_before", {31'd0, overrun}, {31'd0, model_ovr});
    send(8'h14, 1'b1, -1, 100); model_frame(8'h14, 1'b1);
    chk("ovr_after", {31'd0, overrun}, {31'd0, model_ovr});
    tready = 1'b1;
    repeat (8) tick();
    exp_q = model_fifo;
    model_fifo.delete();
    check_beats("ovr_drain");
    repeat (20) tick();
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    do_reset();
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Full FIFO with a pop in the same cycle as the fifth push
    tready = 1'b0;
    for (int i = 0; i < 5; i++) rb[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) send(rb[i], 1'b1, -1, 100);
    send(rb[4], 1'b1, 97, 100);
    tready = 1'b0;
    chk("fp_overrun", {31'd0, overrun}, 32'd0);
    chk("fp_tvalid", {31'd0, tvalid}, 32'd1);
    chk("fp_head", {24'd0, tdata}, {24'd0, rb[1]});
    tready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) model_frame(rb[i], 1'b0);
    check_beats("fp_drain");

    // Random burst under back-pressure against the bounded-queue model
    k = $urandom_range(1, 6);
    tready = 1'b0;
    for (int i = 0; i < k; i++) begin
      b = 8'($urandom);
      send(b, 1'b1, -1, 100);
      model_frame(b, 1'b1);
    end
    chk("rbp_overrun", {31'd0, overrun}, {31'd0, model_ovr});
    tready = 1'b1;
    repeat (8) tick();
    exp_q = model_fifo;
    model_fifo.delete();
    check_beats("rbp_drain");
    do_reset();

    // Reset in the middle of a frame with bytes queued
    tready = 1'b0;
    send(8'($urandom), 1'b1, -1, 100);
    send(8'($urandom), 1'b1, -1, 100);
    send(8'hFF, 1'b1, -1, 55);
    rst_n = 1'b0;
    #1;
    chk("mid_tvalid", {31'd0, tvalid}, 32'd0);
    chk("mid_tdata", {24'd0, tdata}, 32'd0);
    chk("mid_tlast", {31'd0, tlast}, 32'd0);
    chk("mid_overrun", {31'd0, overrun}, 32'd0);
    chk("mid_frame_err", {31'd0, frame_err}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    beats.delete();
    beat_cyc.delete();
    fe_count = 0;
    repeat (3) tick();
    chk("post_rst_tvalid", {31'd0, tvalid}, 32'd0);
    tready = 1'b1;
    send(8'h42, 1'b1, -1, 100); model_frame(8'h42, 1'b0);
    repeat (5) tick();
    check_beats("post_rst");
    chk("post_rst_fe", fe_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
